cell_test_unit: RTL



---
 rtl/cell_test_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/cell_test_unit.sv
// Nock structural test execute unit: cell/atom test on an operand word, loobean
// result written back as an atom node in place or at the allocator free address.
module cell_test_unit #(
  parameter int                ADDR_W   = 28,
  parameter int                DATA_W   = 64,
  parameter logic [ADDR_W-1:0] NIL_VAL  = {ADDR_W{1'b1}},
  parameter logic              ATOM_TAG = 1'b0,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_sel,
  input  logic              dest_sel,
  input  logic [ADDR_W-1:0] cell_address,
  input  logic [DATA_W-1:0] cell_data,
  input  logic [ADDR_W-1:0] free_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic              mem_execute,
  output logic [ADDR_W-1:0] address1,
  output logic [ADDR_W-1:0] address2,
  output logic [1:0]        mem_func,
  output logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              result,
  output logic [7:0]        cell_error
);

  localparam logic [1:0] GET_CONTENTS = 2'd1;
  localparam logic [1:0] SET_CONTENTS = 2'd2;
  localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);
  localparam logic [7:0] ERR_NONE     = 8'd0;
  localparam logic [7:0] ERR_READ     = 8'd1;
  localparam logic [7:0] ERR_WRITE    = 8'd2;
  localparam logic [7:0] ERR_NIL      = 8'd3;

  if (DATA_W < 2*ADDR_W+2) begin : g_width_check
    $error("cell_test_unit: DATA_W must be >= 2*ADDR_W+2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ_WAIT, S_WRITE_REQ, S_WRITE_WAIT, S_ERROR
  } state_t;

  state_t            state;
  logic              start_ff;
  logic              op_inv;
  logic              op_is_cell;
  logic              op_tel_tag;
  logic [ADDR_W-1:0] op_tel;
  logic [ADDR_W-1:0] dest_addr;
  logic [7:0]        tmo_cnt;

  logic              launch;
  logic              abort;
  logic              ack;
  logic              tmo_hit;
  logic              wrapped_atom;
  logic              res_bit;
  logic [DATA_W-1:0] result_word;
  logic              unused_bits;

  assign address2 = '0;
  assign launch   = start & ~start_ff;
  assign abort    = ~start & busy;
  // A ready coinciding with our own request pulse belongs to an earlier request.
  assign ack      = mem_ready & ~mem_execute;
  assign tmo_hit  = (TIMEOUT_C != 8'd0) && ((tmo_cnt + 8'd1) == TIMEOUT_C);
  assign res_bit  = ~op_is_cell ^ op_inv;

  assign wrapped_atom = (read_data1[ADDR_W-1:0] == NIL_VAL) &&
                        (read_data1[2*ADDR_W+1] == ATOM_TAG) &&
                        (read_data1[2*ADDR_W]   == ATOM_TAG);

  assign unused_bits = ^{read_data2, read_data1, cell_data};

  // NOTE: every bit gets a value before any partial overwrite, so no latch is inferred.
  always_comb begin
    result_word                = '0;
    result_word[ADDR_W-1:0]    = NIL_VAL;
    result_word[ADDR_W]        = res_bit;
    result_word[2*ADDR_W]      = ATOM_TAG;
    result_word[2*ADDR_W+1]    = ATOM_TAG;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      start_ff    <= 1'b0;
      op_inv      <= 1'b0;
      op_is_cell  <= 1'b0;
      op_tel_tag  <= 1'b0;
      op_tel      <= '0;
      dest_addr   <= '0;
      tmo_cnt     <= '0;
      mem_execute <= 1'b0;
      address1    <= '0;
      mem_func    <= 2'd0;
      write_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 1'b0;
      cell_error  <= ERR_NONE;
    end else begin
      start_ff <= start;
      // NOTE: non-blocking default makes done a single-cycle pulse unless re-asserted below.
      done     <= 1'b0;
      if (launch) begin
        op_inv      <= op_sel;
        op_tel      <= cell_data[ADDR_W-1:0];
        op_tel_tag  <= cell_data[2*ADDR_W];
        dest_addr   <= dest_sel ? free_addr : cell_address;
        cell_error  <= ERR_NONE;
        result      <= 1'b0;
        tmo_cnt     <= '0;
        mem_execute <= 1'b0;
        mem_func    <= 2'd0;
        busy        <= 1'b1;
        state       <= S_CHECK;
      end else if (abort) begin
        mem_execute <= 1'b0;
        mem_func    <= 2'd0;
        busy        <= 1'b0;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_CHECK: begin
            if (op_tel_tag == ATOM_TAG) begin
              op_is_cell <= 1'b0;
              state      <= S_WRITE_REQ;
            end else if (op_tel == NIL_VAL) begin
              cell_error <= ERR_NIL;
              busy       <= 1'b0;
              state      <= S_ERROR;
            end else begin
              address1    <= op_tel;
              mem_func    <= GET_CONTENTS;
              mem_execute <= 1'b1;
              state       <= S_READ_WAIT;
            end
          end
          S_READ_WAIT: begin
            mem_execute <= 1'b0;
            mem_func    <= 2'd0;
            if (ack) begin
              op_is_cell <= ~wrapped_atom;
              tmo_cnt    <= '0;
              state      <= S_WRITE_REQ;
            end else if (tmo_hit) begin
              cell_error <= ERR_READ;
              busy       <= 1'b0;
              state      <= S_ERROR;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
          S_WRITE_REQ: begin
            address1    <= dest_addr;
            write_data  <= result_word;
            mem_func    <= SET_CONTENTS;
            mem_execute <= 1'b1;
            state       <= S_WRITE_WAIT;
          end
          S_WRITE_WAIT: begin
            mem_execute <= 1'b0;
            mem_func    <= 2'd0;
            if (ack) begin
              done   <= 1'b1;
              result <= res_bit;
              busy   <= 1'b0;
              state  <= S_IDLE;
            end else if (tmo_hit) begin
              cell_error <= ERR_WRITE;
              busy       <= 1'b0;
              state      <= S_ERROR;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
